// File: rtl/wb_trace_encoder.sv
// Writeback-stage commit trace encoder: packs register writes and taken branches into
// 40-bit records held in a show-ahead FIFO. Optional macro: TRACE_FILTER_EN (REG_MASK filter).
module wb_trace_encoder #(
  parameter int          DEPTH    = 8,
  parameter int          CNT_W    = 16,
  parameter logic [15:0] REG_MASK = 16'hFFFF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             RegWriteW,
  input  logic [3:0]             WA3W,
  input  logic [31:0]            wd3,
  input  logic [3:0]             wa3_2,
  input  logic [31:0]            wd3_2,
  input  logic                   PCSrcW,
  output logic                   trace_valid,
  input  logic                   trace_ready,
  output logic [39:0]            trace_data,
  output logic [$clog2(DEPTH):0] level,
  output logic [CNT_W-1:0]       drop_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = LW + 1;

  localparam logic [1:0] KIND_REG    = 2'b00;
  localparam logic [1:0] KIND_BRANCH = 2'b01;
  localparam logic [1:0] KIND_MARKER = 2'b10;

  logic [39:0]      mem_q [DEPTH];
  logic [39:0]      mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic             ev_p1, ev_p2, ev_br;
  logic             pend, pop, admit;
  logic [1:0]       n;
  logic [2:0]       need;
  logic [2:0]       push_cnt;
  logic [FW-1:0]    free;
  logic [CNT_W:0]   drop_sum;
  logic [39:0]      recs [4];

`ifdef TRACE_FILTER_EN
  assign ev_p1 = RegWriteW[0] & REG_MASK[WA3W];
  assign ev_p2 = RegWriteW[1] & REG_MASK[wa3_2];
`else
  logic unused_mask;
  assign unused_mask = ^REG_MASK;
  assign ev_p1 = RegWriteW[0];
  assign ev_p2 = RegWriteW[1];
`endif
  assign ev_br = PCSrcW;

  assign n           = {1'b0, ev_p1} + {1'b0, ev_p2} + {1'b0, ev_br};
  assign pend        = (drop_q != '0);
  assign trace_valid = (level_q != '0);
  assign trace_data  = trace_valid ? mem_q[rd_ptr_q] : '0;
  assign level       = level_q;
  assign drop_count  = drop_q;

  // Records are compacted marker-first so the whole cycle is admitted or dropped as one unit.
  always_comb begin
    for (int i = 0; i < 4; i++) recs[i] = '0;
    need = '0;
    if (pend) begin
      recs[need[1:0]] = {KIND_MARKER, 4'd0, 2'b00, 32'(drop_q)};
      need = need + 3'd1;
    end
    if (ev_p1) begin
      recs[need[1:0]] = {KIND_REG, WA3W, 2'b00, wd3};
      need = need + 3'd1;
    end
    if (ev_p2) begin
      recs[need[1:0]] = {KIND_REG, wa3_2, 2'b00, wd3_2};
      need = need + 3'd1;
    end
    if (ev_br) begin
      recs[need[1:0]] = {KIND_BRANCH, 4'd0, 2'b00, wd3};
      need = need + 3'd1;
    end

    pop      = trace_valid & trace_ready;
    free     = FW'(DEPTH) - FW'(level_q) + FW'(pop);
    admit    = (FW'(need) <= free);
    push_cnt = admit ? need : 3'd0;

    drop_sum = {1'b0, drop_q} + (CNT_W+1)'(n);
    if (admit)                drop_d = '0;
    else if (drop_sum[CNT_W]) drop_d = '1;
    else                      drop_d = drop_sum[CNT_W-1:0];

    mem_d = mem_q;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < push_cnt) mem_d[wr_ptr_q + AW'(i)] = recs[i];
    end

    wr_ptr_d = wr_ptr_q + AW'(push_cnt);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q - LW'(pop) + LW'(push_cnt);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: contents are only visible through a nonzero level.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_wb_trace_encoder.sv
// Directed self-checking bench for wb_trace_encoder (DEPTH=8, CNT_W=16).
// Honours TRACE_FILTER_EN by overriding REG_MASK to 16'hFFFE.
module tb_wb_trace_encoder;

  logic        clk;
  logic        reset;
  logic [1:0]  RegWriteW;
  logic [3:0]  WA3W;
  logic [31:0] wd3;
  logic [3:0]  wa3_2;
  logic [31:0] wd3_2;
  logic        PCSrcW;
  logic        trace_valid;
  logic        trace_ready;
  logic [39:0] trace_data;
  logic [3:0]  level;
  logic [15:0] drop_count;

  int total;
  int bad;

  wb_trace_encoder #(
    .DEPTH(8),
    .CNT_W(16)
`ifdef TRACE_FILTER_EN
    , .REG_MASK(16'hFFFE)
`endif
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .RegWriteW  (RegWriteW),
    .WA3W       (WA3W),
    .wd3        (wd3),
    .wa3_2      (wa3_2),
    .wd3_2      (wd3_2),
    .PCSrcW     (PCSrcW),
    .trace_valid(trace_valid),
    .trace_ready(trace_ready),
    .trace_data (trace_data),
    .level      (level),
    .drop_count (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [39:0] rec(input logic [1:0] k, input logic [3:0] r, input logic [31:0] v);
    return {k, r, 2'b00, v};
  endfunction

  task automatic drive_idle();
    RegWriteW = 2'b00; WA3W = 4'd0; wd3 = 32'd0;
    wa3_2 = 4'd0; wd3_2 = 32'd0; PCSrcW = 1'b0;
  endtask

  task automatic drive_write(input logic [3:0] r, input logic [31:0] v);
    RegWriteW = 2'b01; WA3W = r; wd3 = v;
    wa3_2 = 4'd0; wd3_2 = 32'd0; PCSrcW = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; trace_ready = 1'b0; drive_idle();
    repeat (2) @(negedge clk);
    total++; if (trace_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b want 0", trace_valid); end
    total++; if (trace_data !== 40'd0) begin bad++; $display("[TB] FAIL reset_data: got %h want 0", trace_data); end
    total++; if (level !== 4'd0) begin bad++; $display("[TB] FAIL reset_level: got %0d want 0", level); end
    total++; if (drop_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_drop: got %0d want 0", drop_count); end
    reset = 1'b0;
  endtask

  task automatic test_single_write();
    @(negedge clk); trace_ready = 1'b1; drive_write(4'd0, 32'd10);
    @(negedge clk); drive_idle();
    total++; if (trace_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid: got %b want 1", trace_valid); end
    total++; if (trace_data !== 40'h00_0000000A) begin bad++; $display("[TB] FAIL single_data: got %h want 000000000a", trace_data); end
    total++; if (level !== 4'd1) begin bad++; $display("[TB] FAIL single_level: got %0d want 1", level); end
    @(negedge clk);
    total++; if (level !== 4'd0) begin bad++; $display("[TB] FAIL single_drained: got %0d want 0", level); end
    total++; if (trace_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_valid_low: got %b want 0", trace_valid); end
  endtask

  task automatic test_multi_event();
    logic [39:0] exp [3];
    exp[0] = 40'h10_00000001;
    exp[1] = 40'h14_00000002;
    exp[2] = 40'h40_00000001;
    @(negedge clk); trace_ready = 1'b0;
    RegWriteW = 2'b11; WA3W = 4'd4; wd3 = 32'h1; wa3_2 = 4'd5; wd3_2 = 32'h2; PCSrcW = 1'b1;
    @(negedge clk); drive_idle();
    total++; if (level !== 4'd3) begin bad++; $display("[TB] FAIL multi_level: got %0d want 3", level); end
    trace_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++; if (trace_data !== exp[k]) begin bad++; $display("[TB] FAIL multi_rec%0d: got %h want %h", k, trace_data, exp[k]); end
      @(negedge clk);
    end
    total++; if (level !== 4'd0) begin bad++; $display("[TB] FAIL multi_drained: got %0d want 0", level); end
  endtask

  task automatic test_overflow();
    logic [39:0] exp_q [$];
    trace_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); drive_write(4'(i), 32'(100 + i));
    end
    @(negedge clk);
    total++; if (level !== 4'd8) begin bad++; $display("[TB] FAIL ovf_full: got %0d want 8", level); end
    drive_write(4'd8, 32'd108);
    for (int d = 1; d <= 3; d++) begin
      @(negedge clk);
      total++; if (drop_count !== 16'(d)) begin bad++; $display("[TB] FAIL ovf_drop%0d: got %0d want %0d", d, drop_count, d); end
      if (d < 3) drive_write(4'(8 + d), 32'(108 + d));
      else begin drive_idle(); trace_ready = 1'b1; end
    end
    total++; if (level !== 4'd8) begin bad++; $display("[TB] FAIL ovf_level_held: got %0d want 8", level); end
    @(negedge clk);
    total++; if (drop_count !== 16'd0) begin bad++; $display("[TB] FAIL ovf_drop_clear: got %0d want 0", drop_count); end
    total++; if (level !== 4'd8) begin bad++; $display("[TB] FAIL ovf_marker_level: got %0d want 8", level); end
    total++; if (trace_data !== rec(2'b00, 4'd1, 32'd101)) begin bad++; $display("[TB] FAIL ovf_head: got %h want %h", trace_data, rec(2'b00, 4'd1, 32'd101)); end
    drive_write(4'd12, 32'd200);
    @(negedge clk); drive_idle();
    total++; if (level !== 4'd8) begin bad++; $display("[TB] FAIL ovf_after_event: got %0d want 8", level); end
    for (int i = 2; i < 8; i++) exp_q.push_back(rec(2'b00, 4'(i), 32'(100 + i)));
    exp_q.push_back(rec(2'b10, 4'd0, 32'd3));
    exp_q.push_back(rec(2'b00, 4'd12, 32'd200));
    for (int k = 0; k < 8; k++) begin
      total++; if (trace_data !== exp_q[k]) begin bad++; $display("[TB] FAIL ovf_drain%0d: got %h want %h", k, trace_data, exp_q[k]); end
      @(negedge clk);
    end
    total++; if (level !== 4'd0) begin bad++; $display("[TB] FAIL ovf_empty: got %0d want 0", level); end
  endtask

  task automatic test_back_to_back();
    logic [39:0] exp_q [$];
    trace_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); drive_write(4'(i), 32'(300 + i));
    end
    @(negedge clk);
    total++; if (level !== 4'd8) begin bad++; $display("[TB] FAIL b2b_full: got %0d want 8", level); end
    trace_ready = 1'b1; drive_write(4'd0, 32'd400);
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      total++; if (level !== 4'd8) begin bad++; $display("[TB] FAIL b2b_level%0d: got %0d want 8", j, level); end
      total++; if (drop_count !== 16'd0) begin bad++; $display("[TB] FAIL b2b_drop%0d: got %0d want 0", j, drop_count); end
      total++; if (trace_data !== rec(2'b00, 4'(j), 32'(300 + j))) begin bad++; $display("[TB] FAIL b2b_head%0d: got %h want %h", j, trace_data, rec(2'b00, 4'(j), 32'(300 + j))); end
      if (j < 4) drive_write(4'(j), 32'(400 + j));
      else drive_idle();
    end
    for (int i = 4; i < 8; i++) exp_q.push_back(rec(2'b00, 4'(i), 32'(300 + i)));
    for (int i = 0; i < 4; i++) exp_q.push_back(rec(2'b00, 4'(i), 32'(400 + i)));
    for (int k = 0; k < 8; k++) begin
      total++; if (trace_data !== exp_q[k]) begin bad++; $display("[TB] FAIL b2b_drain%0d: got %h want %h", k, trace_data, exp_q[k]); end
      @(negedge clk);
    end
    total++; if (level !== 4'd0) begin bad++; $display("[TB] FAIL b2b_empty: got %0d want 0", level); end
  endtask

  task automatic test_atomic_drop();
    logic [39:0] exp_q [$];
    trace_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); drive_write(4'(i), 32'(500 + i));
    end
    @(negedge clk);
    total++; if (level !== 4'd6) begin bad++; $display("[TB] FAIL atom_fill: got %0d want 6", level); end
    RegWriteW = 2'b11; WA3W = 4'd1; wd3 = 32'h11; wa3_2 = 4'd2; wd3_2 = 32'h22; PCSrcW = 1'b1;
    @(negedge clk); drive_idle();
    total++; if (level !== 4'd6) begin bad++; $display("[TB] FAIL atom_level: got %0d want 6", level); end
    total++; if (drop_count !== 16'd3) begin bad++; $display("[TB] FAIL atom_drop: got %0d want 3", drop_count); end
    trace_ready = 1'b1;
    @(negedge clk);
    total++; if (drop_count !== 16'd0) begin bad++; $display("[TB] FAIL atom_drop_clear: got %0d want 0", drop_count); end
    total++; if (level !== 4'd6) begin bad++; $display("[TB] FAIL atom_marker_level: got %0d want 6", level); end
    for (int i = 1; i < 6; i++) exp_q.push_back(rec(2'b00, 4'(i), 32'(500 + i)));
    exp_q.push_back(rec(2'b10, 4'd0, 32'd3));
    for (int k = 0; k < 6; k++) begin
      total++; if (trace_data !== exp_q[k]) begin bad++; $display("[TB] FAIL atom_drain%0d: got %h want %h", k, trace_data, exp_q[k]); end
      @(negedge clk);
    end
    total++; if (level !== 4'd0) begin bad++; $display("[TB] FAIL atom_empty: got %0d want 0", level); end
  endtask

  task automatic test_reset_mid_stream();
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); drive_write(4'(i), 32'(600 + i));
    end
    @(negedge clk);
    total++; if (level !== 4'd5) begin bad++; $display("[TB] FAIL rst_pre_level: got %0d want 5", level); end
    reset = 1'b1; drive_write(4'd9, 32'd999);
    @(negedge clk);
    reset = 1'b0; drive_idle();
    total++; if (trace_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid: got %b want 0", trace_valid); end
    total++; if (level !== 4'd0) begin bad++; $display("[TB] FAIL rst_level: got %0d want 0", level); end
    total++; if (drop_count !== 16'd0) begin bad++; $display("[TB] FAIL rst_drop: got %0d want 0", drop_count); end
    total++; if (trace_data !== 40'd0) begin bad++; $display("[TB] FAIL rst_data: got %h want 0", trace_data); end
    @(negedge clk);
    total++; if (level !== 4'd0) begin bad++; $display("[TB] FAIL rst_event_ignored: got %0d want 0", level); end
  endtask

  task automatic test_filter();
    trace_ready = 1'b0;
    @(negedge clk);
    RegWriteW = 2'b11; WA3W = 4'd0; wd3 = 32'd7; wa3_2 = 4'd1; wd3_2 = 32'd9; PCSrcW = 1'b0;
    @(negedge clk); drive_idle();
    total++; if (drop_count !== 16'd0) begin bad++; $display("[TB] FAIL filt_drop: got %0d want 0", drop_count); end
`ifdef TRACE_FILTER_EN
    total++; if (level !== 4'd1) begin bad++; $display("[TB] FAIL filt_level: got %0d want 1", level); end
    total++; if (trace_data !== 40'h04_00000009) begin bad++; $display("[TB] FAIL filt_head: got %h want 0400000009", trace_data); end
`else
    total++; if (level !== 4'd2) begin bad++; $display("[TB] FAIL filt_level: got %0d want 2", level); end
    total++; if (trace_data !== 40'h00_00000007) begin bad++; $display("[TB] FAIL filt_head: got %h want 0000000007", trace_data); end
`endif
    trace_ready = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (level !== 4'd0) begin bad++; $display("[TB] FAIL filt_empty: got %0d want 0", level); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_single_write();
    test_multi_event();
    test_overflow();
    test_back_to_back();
    test_atomic_drop();
    test_reset_mid_stream();
    test_filter();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
